dispense_scheduler: RTL and testbench

Shares one physical product-dispense motor among several vending lanes. Each lane's vending controller emits one-cycle dispense pulses. This block queues those pulses per lane, grants the motor round-robin, and drives it for a fixed on-time followed by a mandatory cooldown. It sits between the vending state machines and the motor driver pin.

---
 rtl/dispense_scheduler.sv | 163 ++++++++++++++++
 tb/tb_dispense_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispense_scheduler.sv
// Shares one dispense motor among NUM_LANES vending lanes: per-lane pending
// queues, round-robin grant, fixed motor on-time followed by a forced cooldown.
module dispense_scheduler #(
  parameter int NUM_LANES       = 4,
  parameter int MOTOR_CYCLES    = 500000,
  parameter int COOLDOWN_CYCLES = 100000,
  parameter int PEND_MAX        = 3
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_LANES-1:0]                  dispenseReq,
  output logic                                  motorOn,
  output logic [((NUM_LANES > 1) ? $clog2(NUM_LANES) : 1)-1:0] laneSel,
  output logic [NUM_LANES-1:0]                  laneDone,
  output logic [NUM_LANES-1:0]                  overflow,
  output logic                                  busy
);

  localparam int SW   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int PW   = (PEND_MAX > 1) ? $clog2(PEND_MAX + 1) : 1;
  localparam int MAXC = (MOTOR_CYCLES > COOLDOWN_CYCLES) ? MOTOR_CYCLES : COOLDOWN_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] MOTOR_LOAD = CW'(MOTOR_CYCLES - 1);
  localparam logic [CW-1:0] COOL_LOAD  = CW'(COOLDOWN_CYCLES - 1);
  localparam logic [PW-1:0] PEND_FULL  = PW'(PEND_MAX);
  localparam logic [SW-1:0] LAST_RST   = SW'(NUM_LANES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_COOL = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]        lane_sel_q, lane_sel_d;
  logic [SW-1:0]        last_q, last_d;
  logic [PW-1:0]        pend_q [NUM_LANES];
  logic [PW-1:0]        pend_d [NUM_LANES];
  logic [NUM_LANES-1:0] done_q, done_d;
  logic [NUM_LANES-1:0] ovf_q, ovf_d;
  logic                 motor_on_q, motor_on_d;
  logic                 busy_q, busy_d;

  logic                 grant_valid_s;
  logic [SW-1:0]        grant_idx_s;
  logic                 grant_s;

  // Round-robin search starting just after the last granted lane.
  always_comb begin : arb_comb
    int idx;
    idx           = 0;
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      idx = (int'(last_q) + k) % NUM_LANES;
      if (!grant_valid_s && (pend_q[idx] != '0)) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = SW'(idx);
      end
    end
  end

  // FSM next state, cycle counter and grant bookkeeping.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lane_sel_d = lane_sel_q;
    last_d     = last_q;
    done_d     = '0;
    grant_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid_s) begin
          grant_s    = 1'b1;
          lane_sel_d = grant_idx_s;
          last_d     = grant_idx_s;
          cnt_d      = MOTOR_LOAD;
          state_d    = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          cnt_d              = COOL_LOAD;
          done_d[lane_sel_q] = 1'b1;
          state_d            = ST_COOL;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_COOL: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    motor_on_d = (state_d == ST_RUN);
    busy_d     = (state_d != ST_IDLE);
  end

  // Per-lane queues: a request and a grant in the same cycle cancel out.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (dispenseReq[i] && !(grant_s && (grant_idx_s == SW'(i)))) begin
        if (pend_q[i] == PEND_FULL) begin
          ovf_d[i] = 1'b1;
        end else begin
          pend_d[i] = pend_q[i] + PW'(1);
        end
      end else if (!dispenseReq[i] && grant_s && (grant_idx_s == SW'(i))) begin
        pend_d[i] = pend_q[i] - PW'(1);
      end else begin
        pend_d[i] = pend_q[i];
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      lane_sel_q <= '0;
      last_q     <= LAST_RST;
      done_q     <= '0;
      ovf_q      <= '0;
      motor_on_q <= 1'b0;
      busy_q     <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        pend_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lane_sel_q <= lane_sel_d;
      last_q     <= last_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      motor_on_q <= motor_on_d;
      busy_q     <= busy_d;
      for (int i = 0; i < NUM_LANES; i++) begin
        pend_q[i] <= pend_d[i];
      end
    end
  end

  assign motorOn  = motor_on_q;
  assign laneSel  = lane_sel_q;
  assign laneDone = done_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_dispense_scheduler.sv
// Directed bench for dispense_scheduler with MOTOR_CYCLES=4, COOLDOWN_CYCLES=2.
module tb_dispense_scheduler;

  localparam int NL = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NL-1:0] dispenseReq = '0;
  logic          motorOn;
  logic [1:0]    laneSel;
  logic [NL-1:0] laneDone;
  logic [NL-1:0] overflow;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic prev_motor;
  int grant_lane_q[$];
  int grant_cyc_q[$];
  int done_cnt[NL];
  int ov_cnt[NL];
  int ov_cyc;

  dispense_scheduler #(
    .NUM_LANES(4), .MOTOR_CYCLES(4), .COOLDOWN_CYCLES(2), .PEND_MAX(3)
  ) dut (
    .clk(clk), .reset(reset), .dispenseReq(dispenseReq), .motorOn(motorOn),
    .laneSel(laneSel), .laneDone(laneDone), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // One clock; observe 1 time unit after the edge and log grants/pulses.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (motorOn && !prev_motor) begin
      grant_lane_q.push_back(int'(laneSel));
      grant_cyc_q.push_back(cyc);
    end
    prev_motor = motorOn;
    for (int i = 0; i < NL; i++) begin
      if (laneDone[i]) done_cnt[i]++;
      if (overflow[i]) begin
        ov_cnt[i]++;
        ov_cyc = cyc;
      end
    end
  endtask

  task automatic clear_log();
    cyc = -1;
    prev_motor = motorOn;
    grant_lane_q.delete();
    grant_cyc_q.delete();
    for (int i = 0; i < NL; i++) begin
      done_cnt[i] = 0;
      ov_cnt[i] = 0;
    end
    ov_cyc = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dispenseReq = '0;
    step();
    step();
    reset = 1'b0;
    clear_log();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (motorOn !== 1'b0 || busy !== 1'b0 || laneSel !== 2'd0 ||
        laneDone !== 4'b0000 || overflow !== 4'b0000) begin
      errors++;
      $display("FAIL reset_values motorOn=%b busy=%b laneSel=%0d laneDone=%b overflow=%b expected 0/0/0/0000/0000",
               motorOn, busy, laneSel, laneDone, overflow);
    end
  endtask

  task automatic test_single();
    do_reset();
    dispenseReq = 4'b0001;
    step();
    dispenseReq = '0;
    checks++;
    if (motorOn !== 1'b0) begin
      errors++;
      $display("FAIL single_latency cyc=%0d motorOn=%b expected 0", cyc, motorOn);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (motorOn !== 1'b1 || laneSel !== 2'd0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_on cyc=%0d motorOn=%b laneSel=%0d busy=%b expected 1/0/1",
                 cyc, motorOn, laneSel, busy);
      end
    end
    step();
    checks++;
    if (motorOn !== 1'b0 || laneDone !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_done cyc=%0d motorOn=%b laneDone=%b busy=%b expected 0/0001/1",
               cyc, motorOn, laneDone, busy);
    end
    step();
    checks++;
    if (laneDone !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_cool cyc=%0d laneDone=%b busy=%b expected 0000/1", cyc, laneDone, busy);
    end
    step();
    checks++;
    if (busy !== 1'b0 || motorOn !== 1'b0) begin
      errors++;
      $display("FAIL single_idle cyc=%0d busy=%b motorOn=%b expected 0/0", cyc, busy, motorOn);
    end
  endtask

  task automatic test_fairness();
    int exp_lane[4];
    int exp_cyc[4];
    exp_lane = '{0, 1, 2, 3};
    exp_cyc  = '{1, 8, 15, 22};
    do_reset();
    dispenseReq = 4'b1111;
    step();
    dispenseReq = '0;
    repeat (32) step();
    checks++;
    if (grant_lane_q.size() != 4) begin
      errors++;
      $display("FAIL fair_count grants=%0d expected 4", grant_lane_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (grant_lane_q[k] != exp_lane[k] || grant_cyc_q[k] != exp_cyc[k]) begin
          errors++;
          $display("FAIL fair_grant%0d lane=%0d cyc=%0d expected lane=%0d cyc=%0d",
                   k, grant_lane_q[k], grant_cyc_q[k], exp_lane[k], exp_cyc[k]);
        end
      end
    end
    for (int i = 0; i < NL; i++) begin
      checks++;
      if (done_cnt[i] != 1) begin
        errors++;
        $display("FAIL fair_done lane=%0d pulses=%0d expected 1", i, done_cnt[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_lane[3];
    int exp_cyc[3];
    exp_lane = '{2, 0, 2};
    exp_cyc  = '{1, 8, 15};
    do_reset();
    dispenseReq = 4'b0100;
    step();
    dispenseReq = '0;
    repeat (5) step();
    checks++;
    if (laneDone !== 4'b0100) begin
      errors++;
      $display("FAIL rr_done cyc=%0d laneDone=%b expected 0100", cyc, laneDone);
    end
    dispenseReq = 4'b0101;
    step();
    dispenseReq = '0;
    checks++;
    if (motorOn !== 1'b0 || laneSel !== 2'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rr_hold cyc=%0d motorOn=%b laneSel=%0d busy=%b expected 0/2/1",
               cyc, motorOn, laneSel, busy);
    end
    repeat (20) step();
    checks++;
    if (grant_lane_q.size() != 3) begin
      errors++;
      $display("FAIL rr_count grants=%0d expected 3", grant_lane_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (grant_lane_q[k] != exp_lane[k] || grant_cyc_q[k] != exp_cyc[k]) begin
          errors++;
          $display("FAIL rr_grant%0d lane=%0d cyc=%0d expected lane=%0d cyc=%0d",
                   k, grant_lane_q[k], grant_cyc_q[k], exp_lane[k], exp_cyc[k]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    dispenseReq = 4'b0010;
    repeat (5) step();
    dispenseReq = '0;
    repeat (34) step();
    checks++;
    if (ov_cnt[1] != 1 || ov_cyc != 4 || ov_cnt[0] != 0 || ov_cnt[2] != 0 || ov_cnt[3] != 0) begin
      errors++;
      $display("FAIL ovf_pulse lane1=%0d at cyc=%0d others=%0d/%0d/%0d expected 1 at 4, 0/0/0",
               ov_cnt[1], ov_cyc, ov_cnt[0], ov_cnt[2], ov_cnt[3]);
    end
    checks++;
    if (done_cnt[1] != 4 || grant_lane_q.size() != 4) begin
      errors++;
      $display("FAIL ovf_vends done=%0d grants=%0d expected 4/4", done_cnt[1], grant_lane_q.size());
    end
  endtask

  task automatic test_req_grant_same_cycle();
    do_reset();
    dispenseReq = 4'b1000;
    repeat (4) step();
    dispenseReq = '0;
    repeat (4) step();
    checks++;
    if (dut.pend_q[3] !== 2'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL same_setup pending=%0d busy=%b expected 3/0", dut.pend_q[3], busy);
    end
    dispenseReq = 4'b1000;
    step();
    dispenseReq = '0;
    checks++;
    if (dut.pend_q[3] !== 2'd3 || motorOn !== 1'b1 || laneSel !== 2'd3) begin
      errors++;
      $display("FAIL same_pending pending=%0d motorOn=%b laneSel=%0d expected 3/1/3",
               dut.pend_q[3], motorOn, laneSel);
    end
    step();
    checks++;
    if (overflow !== 4'b0000) begin
      errors++;
      $display("FAIL same_no_ovf overflow=%b expected 0000", overflow);
    end
    repeat (36) step();
    checks++;
    if (done_cnt[3] != 5 || ov_cnt[3] != 0) begin
      errors++;
      $display("FAIL same_vends done=%0d ovf=%0d expected 5/0", done_cnt[3], ov_cnt[3]);
    end
  endtask

  task automatic test_reset_mid();
    int total;
    do_reset();
    dispenseReq = 4'b0111;
    step();
    dispenseReq = '0;
    step();
    step();
    checks++;
    if (motorOn !== 1'b1 || laneSel !== 2'd0) begin
      errors++;
      $display("FAIL mid_run motorOn=%b laneSel=%0d expected 1/0", motorOn, laneSel);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (motorOn !== 1'b0 || busy !== 1'b0 || laneDone !== 4'b0000 || laneSel !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset motorOn=%b busy=%b laneDone=%b laneSel=%0d expected 0/0/0000/0",
               motorOn, busy, laneDone, laneSel);
    end
    repeat (12) step();
    total = done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3];
    checks++;
    if (grant_lane_q.size() != 1 || total != 0) begin
      errors++;
      $display("FAIL mid_discard grants=%0d done=%0d expected 1/0", grant_lane_q.size(), total);
    end
    dispenseReq = 4'b1000;
    step();
    dispenseReq = '0;
    step();
    checks++;
    if (motorOn !== 1'b1 || laneSel !== 2'd3) begin
      errors++;
      $display("FAIL mid_regrant motorOn=%b laneSel=%0d expected 1/3", motorOn, laneSel);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_round_robin();
    test_overflow();
    test_req_grant_same_cycle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
